// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared state encoding and game constants for the Mastermind sequencer
package mastermind_pkg;
    typedef enum logic [2:0] {
        CODE_ENTRY,
        GUESS_ENTRY,
        CLEAR,
        SCORE,
        CHECK,
        WIN,
        LOSE
    } state_t;
    localparam int NUM_PEGS = 4;
    localparam int PEG_W = 3;
    localparam logic [PEG_W-1:0] WIN_RED = 3'd4;
endpackage

// File: rtl/mastermind_sequencer_press_detect.sv
// press_detect: rising-edge detector turning the debounced load level into a one-cycle press
module press_detect (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    output logic press
);
    logic load_q;
    // delayed copy of load; resets high so a button held through reset is not a press
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) load_q <= 1'b1;
        else load_q <= load;
    end
    assign press = load & ~load_q;
endmodule

// File: rtl/mastermind_sequencer.sv
// mastermind_sequencer: game FSM driving code/guess slot writes, comparator scoring and win/lose
module mastermind_sequencer
    import mastermind_pkg::*;
#(
    parameter int MAX_ROUNDS = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [PEG_W-1:0] data_in,
    input  logic [2:0]       red_in,
    output logic             wr_code,
    output logic             wr_guess,
    output logic [1:0]       wr_idx,
    output logic [PEG_W-1:0] wr_data,
    output logic             clr_score,
    output logic             cmp_en,
    output logic [1:0]       cmp_idx,
    output logic [3:0]       round_num,
    output logic             win,
    output logic             lose,
    output logic             hide_code
);
    localparam logic [1:0] LAST_SLOT = 2'(NUM_PEGS - 1);
    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);
    logic press;
    state_t state, state_d;
    logic [1:0] slot, slot_d, wr_idx_d, cmp_idx_d;
    logic [3:0] round_d;
    logic [PEG_W-1:0] wr_data_d;
    logic wr_code_d, wr_guess_d;
    press_detect u_press (
        .clk    (clk),
        .resetn (resetn),
        .load   (load),
        .press  (press)
    );
    // next state and next registered outputs; entry states leave only after the slot-3 strobe
    // has gone out so a write strobe never overlaps clr_score
    always_comb begin
        state_d = state;
        slot_d = slot;
        round_d = round_num;
        wr_code_d = 1'b0;
        wr_guess_d = 1'b0;
        wr_idx_d = wr_idx;
        wr_data_d = wr_data;
        cmp_idx_d = 2'd0;
        case (state)
            CODE_ENTRY, GUESS_ENTRY: begin
                if ((wr_code || wr_guess) && wr_idx == LAST_SLOT) begin
                    state_d = (state == CODE_ENTRY) ? GUESS_ENTRY : CLEAR;
                end else if (press) begin
                    wr_code_d = (state == CODE_ENTRY);
                    wr_guess_d = (state == GUESS_ENTRY);
                    wr_idx_d = slot;
                    wr_data_d = data_in;
                    slot_d = slot + 2'd1;
                end
            end
            CLEAR: state_d = SCORE;
            SCORE: begin
                state_d = (cmp_idx == LAST_SLOT) ? CHECK : SCORE;
                cmp_idx_d = (cmp_idx == LAST_SLOT) ? 2'd0 : cmp_idx + 2'd1;
            end
            CHECK: begin
                round_d = round_num + 4'd1;
                state_d = (red_in == WIN_RED) ? WIN : ((round_num + 4'd1 == MAX_R) ? LOSE : GUESS_ENTRY);
            end
            WIN, LOSE: begin
                if (press) begin
                    state_d = CODE_ENTRY;
                    round_d = 4'd0;
                    slot_d = 2'd0;
                end
            end
            default: state_d = CODE_ENTRY;
        endcase
    end
    // state, counters and registered strobes aligned with the state they belong to
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= CODE_ENTRY;
            slot <= 2'd0;
            round_num <= 4'd0;
            wr_code <= 1'b0;
            wr_guess <= 1'b0;
            wr_idx <= 2'd0;
            wr_data <= '0;
            clr_score <= 1'b0;
            cmp_en <= 1'b0;
            cmp_idx <= 2'd0;
        end else begin
            state <= state_d;
            slot <= slot_d;
            round_num <= round_d;
            wr_code <= wr_code_d;
            wr_guess <= wr_guess_d;
            wr_idx <= wr_idx_d;
            wr_data <= wr_data_d;
            clr_score <= (state_d == CLEAR);
            cmp_en <= (state_d == SCORE);
            cmp_idx <= cmp_idx_d;
        end
    end
    assign win = (state == WIN);
    assign lose = (state == LOSE);
    assign hide_code = !(state inside {CODE_ENTRY, WIN, LOSE});
endmodule

// File: tb/tb_mastermind_sequencer.sv
// tb_mastermind_sequencer: scoreboard bench for the Mastermind sequencer
module tb_mastermind_sequencer;
    localparam int K_CODE = 0, K_GUESS = 1, K_CLR = 2, K_CMP = 3;
    logic clk = 1'b0, resetn = 1'b0, load = 1'b1;
    logic [2:0] data_in = 3'd0, red_in = 3'd0;
    logic wr_code, wr_guess, clr_score, cmp_en, win, lose, hide_code;
    logic [1:0] wr_idx, cmp_idx;
    logic [2:0] wr_data;
    logic [3:0] round_num;
    logic [6:0] sb[$];
    logic [1:0] mslot = 2'd0;
    int n_chk = 0, n_fail = 0;

    mastermind_sequencer #(.MAX_ROUNDS(2)) dut (
        .clk(clk), .resetn(resetn), .load(load), .data_in(data_in), .red_in(red_in),
        .wr_code(wr_code), .wr_guess(wr_guess), .wr_idx(wr_idx), .wr_data(wr_data),
        .clr_score(clr_score), .cmp_en(cmp_en), .cmp_idx(cmp_idx), .round_num(round_num),
        .win(win), .lose(lose), .hide_code(hide_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(input int k, input logic [1:0] i, input logic [2:0] d);
        sb.push_back({2'(k), i, d});
    endfunction

    // one debounced press; kind < 0 means no strobe is expected
    task automatic press(input logic [2:0] d, input int kind);
        @(negedge clk);
        data_in = d;
        if (kind >= 0) begin
            push(kind, mslot, d);
            mslot = mslot + 2'd1;
        end
        load = 1'b1;
        repeat (2) @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic guess_round(input logic [2:0] red, input bit toggle);
        red_in = red;
        press(3'd1, K_GUESS);
        press(3'd2, K_GUESS);
        press(3'd3, K_GUESS);
        @(negedge clk);
        data_in = 3'd4;
        push(K_GUESS, mslot, 3'd4);
        mslot = mslot + 2'd1;
        push(K_CLR, 2'd0, 3'd0);
        for (int i = 0; i < 4; i++) push(K_CMP, 2'(i), 3'd0);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (toggle) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk) load = 1'b1;
                @(negedge clk) load = 1'b0;
            end
            repeat (3) @(negedge clk);
        end else begin
            repeat (9) @(negedge clk);
        end
    endtask

    // monitor: every strobe cycle pops one expectation and compares kind, index and data
    always @(negedge clk) begin
        if (resetn) begin
            automatic int n = int'(wr_code) + int'(wr_guess) + int'(clr_score) + int'(cmp_en);
            automatic logic [1:0] k = wr_code ? 2'd0 : wr_guess ? 2'd1 : clr_score ? 2'd2 : 2'd3;
            automatic logic wr = wr_code | wr_guess;
            automatic logic [6:0] act = {k, wr ? wr_idx : (cmp_en ? cmp_idx : 2'd0), wr ? wr_data : 3'd0};
            if (!cmp_en) chk("cmp_idx_idle", int'(cmp_idx), 0);
            if (n != 0) begin
                chk("one_strobe", int'(n > 1), 0);
                if (sb.size() == 0) chk("unexpected_strobe", int'(act), -1);
                else chk("strobe", int'(act), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_hide", int'(hide_code), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_lose", int'(lose), 0);
        chk("rst_round", int'(round_num), 0);
        chk("rst_wr_idx", int'(wr_idx), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        press(3'd5, K_CODE);
        press(3'd2, K_CODE);
        press(3'd7, K_CODE);
        press(3'd1, K_CODE);
        chk("guess_hide", int'(hide_code), 1);
        guess_round(3'd4, 1'b0);
        chk("win", int'(win), 1);
        chk("win_round", int'(round_num), 1);
        chk("win_hide", int'(hide_code), 0);
        chk("win_lose", int'(lose), 0);
        press(3'd6, -1);
        mslot = 2'd0;
        chk("restart_win", int'(win), 0);
        chk("restart_round", int'(round_num), 0);
        chk("restart_hide", int'(hide_code), 0);
        press(3'd1, K_CODE);
        press(3'd3, K_CODE);
        press(3'd5, K_CODE);
        press(3'd7, K_CODE);
        guess_round(3'd1, 1'b1);
        chk("r1_round", int'(round_num), 1);
        chk("r1_lose", int'(lose), 0);
        chk("r1_hide", int'(hide_code), 1);
        guess_round(3'd1, 1'b0);
        chk("lose", int'(lose), 1);
        chk("lose_round", int'(round_num), 2);
        chk("lose_win", int'(win), 0);
        chk("lose_hide", int'(hide_code), 0);
        press(3'd2, -1);
        mslot = 2'd0;
        chk("restart_lose", int'(lose), 0);
        chk("restart_round2", int'(round_num), 0);
        @(negedge clk);
        data_in = 3'd6;
        push(K_CODE, mslot, 3'd6);
        mslot = mslot + 2'd1;
        load = 1'b1;
        repeat (50) @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        press(3'd1, K_CODE);
        press(3'd2, K_CODE);
        press(3'd3, K_CODE);
        press(3'd1, K_GUESS);
        press(3'd2, K_GUESS);
        press(3'd3, K_GUESS);
        @(negedge clk);
        push(K_GUESS, mslot, 3'd4);
        push(K_CLR, 2'd0, 3'd0);
        push(K_CMP, 2'd0, 3'd0);
        push(K_CMP, 2'd1, 3'd0);
        data_in = 3'd4;
        load = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_score", int'(cmp_en), 1);
        #2 resetn = 1'b0;
        #1;
        sb.delete();
        chk("ar_cmp_en", int'(cmp_en), 0);
        chk("ar_cmp_idx", int'(cmp_idx), 0);
        chk("ar_clr", int'(clr_score), 0);
        chk("ar_wr", int'(wr_code | wr_guess), 0);
        chk("ar_wr_idx", int'(wr_idx), 0);
        chk("ar_wr_data", int'(wr_data), 0);
        chk("ar_round", int'(round_num), 0);
        chk("ar_hide", int'(hide_code), 0);
        chk("ar_winlose", int'(win | lose), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        mslot = 2'd0;
        press(3'd3, K_CODE);
        repeat (2) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
